gpio_uart_tx: RTL and testbench
===============================

# gpio_uart_tx

Memory-mapped serial output stage that sits directly downstream of the processor's GPIO output register. It accepts 9-bit words on the same write strobe that loads the GPIO register, buffers them in a small FIFO, and transmits each one as an asynchronous serial frame on a single pin. This gives programs a byte-stream debug/output channel without stalling the processor on every bit.

## Interface
Parameters:
- CLKS_PER_BIT, 234, clock cycles per serial bit; 27 MHz / 234 ≈ 115 200 baud; legal range ≥ 2
- FIFO_DEPTH, 4, number of buffered words; power of two, ≥ 2

Ports:
- clock  input  1  system clock; all logic on the rising edge
- resetn  input  1  synchronous, active-low reset
- wr_en  input  1  write strobe, asserted for one cycle per word (same strobe as the GPIO register enable)
- wr_data  input  9  word to transmit (processor DOUT)
- full  output  1  FIFO holds FIFO_DEPTH words
- busy  output  1  frame in progress or FIFO non-empty
- overflow  output  1  sticky: a write was dropped because the FIFO was full
- tx  output  1  serial line, idle high

## Operation
- Frame: 1 start bit (0), 9 data bits LSB first, optional parity bit, 1 stop bit (1).
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: tx = 1. If FIFO non-empty: pop head into shift register, go START.
- START: tx = 0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: tx = shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; after bit 8 go PARITY (macro) or STOP.
- STOP: tx = 1 for CLKS_PER_BIT cycles; then, if FIFO non-empty, pop and go straight to START (no IDLE cycle); else IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, cleared on every state or bit change; width $clog2(CLKS_PER_BIT).
- FIFO push: wr_en=1 and full=0 at the edge. full is evaluated before any same-cycle pop; a write while full is dropped even if a pop occurs that cycle, and sets overflow.
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur; occupancy unchanged.
- overflow clears only on reset.

## Timing
- Reset (resetn=0 at an edge): tx=1, full=0, busy=0, overflow=0, FSM=IDLE, FIFO emptied, counters zero. Reset mid-frame aborts the frame; tx is high from that edge on.
- tx, full, busy, overflow are all registered outputs.
- Write at edge N into an empty FIFO while IDLE: word stored at N; pop and START entered at edge N+1; tx falls at N+1.
- Frame length: 11 × CLKS_PER_BIT cycles (12 × with parity).
- full asserts at the edge that stores the FIFO_DEPTH-th word; deasserts at the edge of the next pop.
- busy asserts at the push edge and deasserts at the edge entering IDLE with an empty FIFO.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state is compiled in; tx = XOR of the 9 data bits (even parity) for CLKS_PER_BIT cycles between the last data bit and stop.
- Not defined: no PARITY state or logic; DATA goes directly to STOP.

## Structure
- Package nano_uart_pkg: FSM state enum, DATA_BITS = 9, frame-length constants (with and without parity).
- Sub-module sync_fifo (parameterised width/depth, push/pop/full/empty, count); FSM, baud counter and shift register in gpio_uart_tx.

## Test plan
- Reset then idle 100 cycles -> tx=1, busy=0, full=0, overflow=0 throughout.
- CLKS_PER_BIT=4, write 9'h1A5 -> tx falls next edge; bits 1,0,1,0,0,1,0,1,1 each 4 cycles; stop high; busy drops after 44 cycles.
- Write 9'h001, 9'h1FF back-to-back -> two frames with no idle gap between stop and second start.
- Six writes in six consecutive cycles during a frame, FIFO_DEPTH=4 -> full asserts; excess writes dropped; overflow=1; only the accepted words are transmitted, in order.
- Assert resetn=0 midway through data bit 4 -> tx=1 from that edge, FIFO empty, no further frames.
- With UART_TX_PARITY_EN, write 9'h007 -> parity bit 1; write 9'h003 -> parity bit 0; frame 12 bit-times.

Source files
------------

// File: rtl/nano_uart_pkg.sv
// nano_uart_pkg
// Shared types and constants for the GPIO serial output stage.
// Contents:
//   DATA_BITS            - width of one transmitted word
//   FRAME_BITS_NO_PARITY - bit-times per frame without parity (start + 9 data + stop)
//   FRAME_BITS_PARITY    - bit-times per frame with parity
//   uart_state_t         - transmitter FSM state encoding
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state to the encoding.
package nano_uart_pkg;

  localparam int DATA_BITS            = 9;
  localparam int FRAME_BITS_NO_PARITY = DATA_BITS + 2;
  localparam int FRAME_BITS_PARITY    = DATA_BITS + 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Small single-clock FIFO with registered occupancy count.
// Parameters: WIDTH (word width), DEPTH (entries, power of two, >= 2)
// Ports:
//   clock   - system clock, rising edge
//   resetn  - synchronous active-low reset, empties the FIFO
//   push    - store wr_data this edge (ignored while full)
//   pop     - discard head this edge (ignored while empty)
//   wr_data - word to store
//   rd_data - current head word (valid while not empty)
//   full    - DEPTH words held
//   empty   - no words held
//   count   - number of words held
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // full and empty come straight from the count register, so a push is judged
  // against the occupancy before any pop that happens on the same edge
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage has no reset; only the pointers and count define validity
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpio_uart_tx.sv
// gpio_uart_tx
// Serial output stage fed by the GPIO write strobe. Words are queued in a
// small FIFO and sent as asynchronous frames: start (0), 9 data bits LSB
// first, optional even parity bit, stop (1).
// Parameters: CLKS_PER_BIT (>= 2), FIFO_DEPTH (power of two, >= 2)
// Ports:
//   clock    - system clock, rising edge
//   resetn   - synchronous active-low reset, aborts any frame
//   wr_en    - one-cycle write strobe
//   wr_data  - 9-bit word to transmit
//   full     - FIFO holds FIFO_DEPTH words
//   busy     - frame in progress or words queued
//   overflow - sticky, a write was dropped while full
//   tx       - serial line, idle high
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit.
module gpio_uart_tx
  import nano_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 busy,
  output logic                 overflow,
  output logic                 tx
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);

  uart_state_t          state;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic [CNT_W-1:0]     fifo_count;
  logic [CNT_W-1:0]     words_after;
  logic                 push_ok;
  logic                 pop;
  logic                 bit_end;
  logic                 frame_after;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .push    (push_ok),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (fifo_rd_data),
    .full    (full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign push_ok = wr_en && !full;

  // The head is taken either from IDLE or on the last cycle of STOP, so
  // consecutive frames run with no idle cycle between them
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

  // busy is registered, so it is computed from what will be true after this edge
  assign frame_after = pop ||
                       ((state != ST_IDLE) && !((state == ST_STOP) && bit_end));
  assign words_after = fifo_count + CNT_W'(push_ok) - CNT_W'(pop);

  // Transmitter FSM with baud counter, shift register and registered outputs.
  // tx is loaded with the value of the upcoming bit on every transition.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      busy <= frame_after || (words_after != '0);
      if (wr_en && full) overflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
          if (pop) begin
            shift <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
            parity <= ^fifo_rd_data;
`endif
            tx    <= 1'b0;
            state <= ST_START;
          end
        end

        ST_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity;
              state <= ST_PARITY;
`else
              tx    <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 4'd1;
              shift   <= {1'b0, shift[DATA_BITS-1:1]};
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
              parity <= ^fifo_rd_data;
`endif
              tx    <= 1'b0;
              state <= ST_START;
            end else begin
              tx    <= 1'b1;
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_uart_tx.sv
// tb_gpio_uart_tx
// Directed bench for gpio_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Inputs are driven and outputs sampled on the falling clock edge.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_gpio_uart_tx;
  import nano_uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = FRAME_BITS_PARITY;
`else
  localparam int NBITS = FRAME_BITS_NO_PARITY;
`endif

  logic       clock   = 1'b0;
  logic       resetn  = 1'b0;
  logic       wr_en   = 1'b0;
  logic [8:0] wr_data = 9'h000;
  logic       full;
  logic       busy;
  logic       overflow;
  logic       tx;

  int checks = 0;
  int errors = 0;

  logic [8:0] pending [$];

  always #5 clock = ~clock;

  gpio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  // Drive the next queued write (one per cycle) or release the strobe
  task automatic drive_next_write();
    if (pending.size() > 0) begin
      wr_en   = 1'b1;
      wr_data = pending.pop_front();
    end else begin
      wr_en = 1'b0;
    end
  endtask

  // Follows one full frame; entered on the falling edge just before the start bit appears
  task automatic expect_frame(input logic [8:0] word, input string tag);
    logic exp;
    for (int b = 0; b < NBITS; b++) begin
      if (b == 0)                exp = 1'b0;
      else if (b <= DATA_BITS)   exp = word[b-1];
      else if (b == NBITS - 1)   exp = 1'b1;
      else                       exp = ^word;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clock);
        drive_next_write();
        checks++;
        if (tx !== exp) begin
          errors++;
          $display("[TB] FAIL %s bit %0d cycle %0d: tx=%b expected %b", tag, b, c, tx, exp);
        end
      end
    end
  endtask

  task automatic check_bit(input logic actual, input logic expected, input string tag);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", tag, actual, expected);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    wr_en  = 1'b0;
    repeat (3) @(negedge clock);
    check_bit(tx, 1'b1, "reset tx");
    check_bit(busy, 1'b0, "reset busy");
    check_bit(full, 1'b0, "reset full");
    check_bit(overflow, 1'b0, "reset overflow");
    resetn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      checks++;
      if ({tx, busy, full, overflow} !== 4'b1000) begin
        errors++;
        $display("[TB] FAIL idle cycle %0d: {tx,busy,full,ovf}=%b expected 1000", i, {tx, busy, full, overflow});
      end
    end
  endtask

  // 9'h1A5 goes out as 1,0,1,0,0,1,0,1,1 after the start bit
  task automatic test_single_frame();
    @(negedge clock);
    wr_en   = 1'b1;
    wr_data = 9'h1A5;
    @(negedge clock);
    wr_en = 1'b0;
    check_bit(tx, 1'b1, "single tx before start");
    check_bit(busy, 1'b1, "single busy at push");
    expect_frame(9'h1A5, "single 1A5");
    check_bit(busy, 1'b1, "single busy in stop");
    @(negedge clock);
    check_bit(busy, 1'b0, "single busy after frame");
    check_bit(tx, 1'b1, "single tx idle");
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    wr_en   = 1'b1;
    wr_data = 9'h001;
    @(negedge clock);
    wr_data = 9'h1FF;
    expect_frame(9'h001, "b2b first");
    expect_frame(9'h1FF, "b2b second");
    @(negedge clock);
    check_bit(busy, 1'b0, "b2b busy after");
  endtask

  // 011,122,033,144 fill the FIFO during frame 0F0; 055 and 166 are dropped
  task automatic test_overflow();
    @(negedge clock);
    wr_en   = 1'b1;
    wr_data = 9'h0F0;
    @(negedge clock);
    wr_data = 9'h011;
    pending = '{9'h122, 9'h033, 9'h144, 9'h055, 9'h166};
    expect_frame(9'h0F0, "ovf frame 0F0");
    check_bit(full, 1'b1, "ovf full after fill");
    check_bit(overflow, 1'b1, "ovf sticky set");
    expect_frame(9'h011, "ovf frame 011");
    check_bit(full, 1'b0, "ovf full after pop");
    expect_frame(9'h122, "ovf frame 122");
    expect_frame(9'h033, "ovf frame 033");
    expect_frame(9'h144, "ovf frame 144");
    @(negedge clock);
    check_bit(busy, 1'b0, "ovf busy after drain");
    check_bit(overflow, 1'b1, "ovf still sticky");
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if (tx !== 1'b1) begin
        errors++;
        $display("[TB] FAIL ovf dropped word sent, cycle %0d: tx=%b expected 1", i, tx);
      end
    end
  endtask

  // Reset lands in the second cycle of data bit 4 of 9'h1A5 with 9'h0AA still queued
  task automatic test_reset_midframe();
    @(negedge clock);
    wr_en   = 1'b1;
    wr_data = 9'h1A5;
    @(negedge clock);
    wr_data = 9'h0AA;
    @(negedge clock);
    wr_en = 1'b0;
    repeat (21) @(negedge clock);
    check_bit(tx, 1'b0, "midframe tx in bit 4");
    resetn = 1'b0;
    @(negedge clock);
    check_bit(tx, 1'b1, "midframe tx after reset");
    check_bit(busy, 1'b0, "midframe busy after reset");
    check_bit(full, 1'b0, "midframe full after reset");
    check_bit(overflow, 1'b0, "midframe overflow cleared");
    resetn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      checks++;
      if ({tx, busy} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL midframe leftover frame, cycle %0d: {tx,busy}=%b expected 10", i, {tx, busy});
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  // 9'h007 has three ones (parity 1), 9'h003 has two (parity 0)
  task automatic test_parity();
    @(negedge clock);
    wr_en   = 1'b1;
    wr_data = 9'h007;
    @(negedge clock);
    wr_en = 1'b0;
    expect_frame(9'h007, "parity 007");
    @(negedge clock);
    check_bit(busy, 1'b0, "parity busy after 007");
    @(negedge clock);
    wr_en   = 1'b1;
    wr_data = 9'h003;
    @(negedge clock);
    wr_en = 1'b0;
    expect_frame(9'h003, "parity 003");
    @(negedge clock);
    check_bit(busy, 1'b0, "parity busy after 003");
  endtask
`endif

  initial begin
    $display("[TB] start, %0d bit-times per frame", NBITS);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
